corner_sb_tile: RTL

Parametrised corner routing tile, successor to the fixed 30-track bottom-left corner tile. It connects a right-side horizontal channel and a top-side vertical channel with corner-turn switch muxes, plus I/O pad injection. Mux selects are loaded through a configuration flip-flop chain into a shadow register, then committed atomically, so routing never glitches while the chain shifts. Tiles daisy-chain through `ccff_head`/`ccff_tail` exactly like the existing fabric tiles.

---
 rtl/corner_tile_pkg.sv | 23 ++
 rtl/corner_cfg_chain.sv | 80 ++++++++
 rtl/corner_sb_tile.sv | 77 +++++++
 3 files changed

// File: rtl/corner_tile_pkg.sv
// Shared select encodings and config-chain sizing for the corner routing tile.
// Define CORNER_TILE_PARITY_EN to append an even-parity bit to the config chain.
package corner_tile_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_TIE0     = 2'd0;
    localparam logic [SEL_W-1:0] SEL_STRAIGHT = 2'd1;
    localparam logic [SEL_W-1:0] SEL_SKEW     = 2'd2;
    localparam logic [SEL_W-1:0] SEL_PAD      = 2'd3;

`ifdef CORNER_TILE_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Two output directions per track, one select each.
    function automatic int unsigned cfg_len(input int unsigned chan_w);
        return 2 * SEL_W * chan_w + (PARITY_EN ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/corner_cfg_chain.sv
// Config shift chain with bit counter, optional parity check and an atomically committed
// active register. Parity is enabled by the CORNER_TILE_PARITY_EN macro (see package).
module corner_cfg_chain
    import corner_tile_pkg::*;
#(
    parameter int unsigned CfgLen = 16,
    parameter int unsigned DataW  = 16
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             ccff_head,
    input  logic             ccff_shift,
    input  logic             cfg_commit,
    output logic             ccff_tail,
    output logic             cfg_valid,
    output logic             cfg_err,
    output logic [DataW-1:0] cfg_sel
);

    localparam int unsigned    CntW   = $clog2(CfgLen + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CfgLen);

    logic [CfgLen-1:0] shadow_q, shadow_d;
    logic [DataW-1:0]  active_q, active_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              parity_ok;
    logic              commit_ok;

    always_comb begin
        parity_ok = PARITY_EN ? ~(^shadow_q) : 1'b1;
        commit_ok = cfg_commit && (bit_cnt_q == CntMax) && parity_ok;

        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        valid_d   = valid_q;
        err_d     = err_q;

        if (ccff_shift) begin
            shadow_d = {shadow_q[CfgLen-2:0], ccff_head};
            if (bit_cnt_q != CntMax) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // Commit sees the pre-shift shadow; a concurrent shift counts as the first new bit.
        if (commit_ok) begin
            active_d  = shadow_q[CfgLen-1 -: DataW];
            valid_d   = 1'b1;
            err_d     = 1'b0;
            bit_cnt_d = ccff_shift ? CntW'(1) : '0;
        end else if (cfg_commit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign ccff_tail = shadow_q[CfgLen-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign cfg_sel   = active_q;

endmodule

// File: rtl/corner_sb_tile.sv
// Parametrised corner switch-box tile: corner-turn 4:1 muxes per output track driven by a
// glitch-free committed config chain. Optional chain parity via CORNER_TILE_PARITY_EN.
module corner_sb_tile
    import corner_tile_pkg::*;
#(
    parameter int unsigned CHAN_W   = 30,
    parameter int unsigned NUM_PADS = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_head,
    input  logic                ccff_shift,
    input  logic                cfg_commit,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_err,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [CHAN_W-1:0]   chany_top_out
);

    localparam int unsigned DataW  = 2 * SEL_W * CHAN_W;
    localparam int unsigned CfgLen = cfg_len(CHAN_W);

    logic [DataW-1:0] cfg_sel;

    corner_cfg_chain #(
        .CfgLen(CfgLen),
        .DataW (DataW)
    ) u_cfg_chain (
        .prog_clk  (prog_clk),
        .prog_reset(prog_reset),
        .ccff_head (ccff_head),
        .ccff_shift(ccff_shift),
        .cfg_commit(cfg_commit),
        .ccff_tail (ccff_tail),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err),
        .cfg_sel   (cfg_sel)
    );

    for (genvar i = 0; i < CHAN_W; i++) begin : g_track
        localparam int unsigned Skew = (i + 1) % CHAN_W;
        localparam int unsigned Pad  = i % NUM_PADS;

        logic [SEL_W-1:0] sel_x, sel_y;
        logic             x_bit, y_bit;

        // Chanx selects occupy the upper half of the data field, track 0 first.
        assign sel_x = cfg_sel[DataW - 1 - SEL_W * i -: SEL_W];
        assign sel_y = cfg_sel[DataW - 1 - SEL_W * (CHAN_W + i) -: SEL_W];

        always_comb begin
            case (sel_x)
                SEL_STRAIGHT: x_bit = chany_top_in[i];
                SEL_SKEW:     x_bit = chany_top_in[Skew];
                SEL_PAD:      x_bit = pad_in[Pad];
                default:      x_bit = 1'b0;
            endcase
        end

        always_comb begin
            case (sel_y)
                SEL_STRAIGHT: y_bit = chanx_right_in[i];
                SEL_SKEW:     y_bit = chanx_right_in[Skew];
                SEL_PAD:      y_bit = pad_in[Pad];
                default:      y_bit = 1'b0;
            endcase
        end

        assign chanx_right_out[i] = x_bit;
        assign chany_top_out[i]   = y_bit;
    end

endmodule
